// File: rtl/sample_hex_pkg.sv
// Shared constants for the sample-to-ASCII-hex formatter: ASCII codes,
// formatter FSM encoding and the nibble-to-character helper.
package sample_hex_pkg;

    localparam logic [7:0] ASCII_DIGIT_BASE  = 8'h30;
    localparam logic [7:0] ASCII_LETTER_BASE = 8'h41;
    localparam logic [7:0] ASCII_LETTER_OFS  = 8'd10;
    localparam logic [7:0] ASCII_CR          = 8'h0D;
    localparam logic [7:0] ASCII_LF          = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_DIGIT_BASE + {4'h0, nib};
        end
        return ASCII_LETTER_BASE + ({4'h0, nib} - ASCII_LETTER_OFS);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO, W bits x 2^DEPTH_LOG2 entries.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int W          = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [W-1:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr_q;
    logic [DEPTH_LOG2:0]   rd_ptr_q;
    logic                  do_push;
    logic                  do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_hex_tx.sv
// Buffers DSP samples and streams each one to a UART transmitter as uppercase
// ASCII hex plus a line terminator; SAMPLE_HEX_CRLF_EN selects CR LF over LF.
module sample_hex_tx
    import sample_hex_pkg::*;
#(
    parameter int W          = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         tx_ready,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    output logic         busy,
    output logic         overflow
);

    localparam int DIGITS = W / 4;
    localparam int CNT_W  = $clog2(DIGITS + 1);
`ifdef SAMPLE_HEX_CRLF_EN
    localparam logic [1:0] TERM_BYTES = 2'd2;
`else
    localparam logic [1:0] TERM_BYTES = 2'd1;
`endif

    state_e             state_q;
    logic [W-1:0]       sh_q, sh_d, src_sh;
    logic [CNT_W-1:0]   cnt_q, cnt_d, src_cnt;
    logic [1:0]         term_q, term_d, src_term;
    logic               last_q, last_d;
    logic               tx_start_q;
    logic [7:0]         tx_data_q, byte_d;
    logic               busy_q, busy_d;
    logic               ovf_q;

    logic [W-1:0]       fifo_rdata;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic               drop, advance, stay_idle, go_idle;

    sync_fifo #(
        .W          (W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Waiting for tx_ready in IDLE keeps a post-reset sample off the line
    // until the transmitter has finished the byte it was already sending.
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty && tx_ready;
    assign drop      = in_valid && fifo_full && !fifo_pop;
    assign advance   = fifo_pop || ((state_q == ST_WAIT_DONE) && tx_ready && !last_q);
    assign stay_idle = (state_q == ST_IDLE) && !fifo_pop;
    assign go_idle   = (state_q == ST_WAIT_DONE) && tx_ready && last_q;
    assign busy_d    = !(stay_idle || go_idle) || !fifo_empty || in_valid;

    // Next byte to send; in IDLE it is taken straight from the FIFO head so
    // tx_start can be registered on the same edge as the pop.
    always_comb begin
        src_sh   = sh_q;
        src_cnt  = cnt_q;
        src_term = term_q;
        if (state_q == ST_IDLE) begin
            src_sh   = fifo_rdata;
            src_cnt  = CNT_W'(DIGITS);
            src_term = TERM_BYTES;
        end
        byte_d = ASCII_LF;
        sh_d   = src_sh;
        cnt_d  = src_cnt;
        term_d = src_term;
        last_d = 1'b0;
        if (src_cnt != '0) begin
            byte_d = hex_ascii(src_sh[W-1 -: 4]);
            sh_d   = src_sh << 4;
            cnt_d  = src_cnt - CNT_W'(1);
        end else begin
            byte_d = (src_term == 2'd2) ? ASCII_CR : ASCII_LF;
            term_d = src_term - 2'd1;
            last_d = (src_term == 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            term_q     <= '0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            busy_q     <= busy_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end
            if (advance) begin
                tx_start_q <= 1'b1;
                tx_data_q  <= byte_d;
                sh_q       <= sh_d;
                cnt_q      <= cnt_d;
                term_q     <= term_d;
                last_q     <= last_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_ready) begin
                        state_q <= last_q ? ST_IDLE : ST_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_sample_hex_tx.sv
// Self-checking bench for sample_hex_tx with a UART-like tx_ready model.
module tb_sample_hex_tx;

    localparam int W          = 16;
    localparam int DEPTH_LOG2 = 4;
    localparam int HOLD       = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         tx_ready;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         busy;
    logic         overflow;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    int   uart_t    = 0;
    logic force_low = 1'b0;

    typedef struct {
        logic [15:0] data;
        logic [31:0] text;
    } vec_t;
    vec_t vecs[5];

    sample_hex_tx #(.W(W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .tx_ready (tx_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Transmitter model: ready drops 2 cycles after tx_start, stays low HOLD cycles.
    assign tx_ready = !force_low && (uart_t < 2);
    always @(posedge clk) begin
        if (tx_start) uart_t <= 1;
        else if (uart_t == HOLD + 1) uart_t <= 0;
        else if (uart_t > 0) uart_t <= uart_t + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + ({4'h0, n} - 8'd10);
    endfunction

    task automatic push_term();
`ifdef SAMPLE_HEX_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
    endtask

    task automatic expect_str(input logic [31:0] s);
        for (int i = 3; i >= 0; i--) exp_q.push_back(s[8*i +: 8]);
        push_term();
    endtask

    task automatic expect_sample(input logic [15:0] d);
        for (int i = 3; i >= 0; i--) exp_q.push_back(hex_char(d[4*i +: 4]));
        push_term();
    endtask

    task automatic drive(input logic [15:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || !tx_ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout: got %0d bytes outstanding expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Byte monitor plus protocol checks.
    logic       prev_start = 1'b0;
    logic       pending    = 1'b0;
    logic [7:0] held       = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
            pending    = 1'b0;
        end else begin
            if (tx_start) begin
                check("start_while_ready", tx_ready, 1);
                check("start_single_cycle", prev_start, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %02h expected none", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_q.pop_front());
                end
                held    = tx_data;
                pending = 1'b1;
            end else if (pending) begin
                check("tx_data_stable", tx_data, held);
                if (!tx_ready) pending = 1'b0;
            end
            prev_start = tx_start;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        logic saw_start;

        vecs[0].data = 16'h0000; vecs[0].text = "0000";
        vecs[1].data = 16'hFFFF; vecs[1].text = "FFFF";
        vecs[2].data = 16'h00C3; vecs[2].text = "00C3";
        vecs[3].data = 16'h9A5E; vecs[3].text = "9A5E";
        vecs[4].data = 16'h7B10; vecs[4].text = "7B10";

        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;

        // Single sample with cycle-2 latency to first tx_start.
        expect_str("1A2F");
        drive(16'h1A2F);
        check("lat_cycle1_start", tx_start, 0);
        check("lat_cycle1_busy", busy, 1);
        @(negedge clk);
        check("lat_cycle2_start", tx_start, 1);
        wait_done("single", 2000);
        check("single_busy_idle", busy, 0);

        for (int i = 0; i < 5; i++) begin
            expect_str(vecs[i].text);
            drive(vecs[i].data);
            wait_done("table", 2000);
            check("table_overflow", overflow, 0);
        end

        // Back-to-back extremes: no stale nibbles carried over.
        expect_str("FFFF");
        expect_str("0000");
        drive(16'hFFFF);
        drive(16'h0000);
        wait_done("b2b", 4000);

        // Fill the FIFO while the transmitter is held busy, then push on the pop cycle.
        @(negedge clk);
        force_low = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 16'h0100 + 16'(i);
            expect_sample(in_data);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("full_no_start", tx_start, 0);
        check("full_overflow", overflow, 0);
        force_low = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0ABC;
        expect_sample(16'h0ABC);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("full_pop", 20000);
        check("full_pop_overflow", overflow, 0);

        // Burst of 20: samples 0..16 fit (one popped early), 17..19 dropped.
        for (int i = 0; i <= 16; i++) expect_sample(16'(i));
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 16'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("burst_overflow_set", overflow, 1);
        wait_done("burst", 20000);
        check("burst_overflow_sticky", overflow, 1);
        expect_sample(16'h0042);
        drive(16'h0042);
        wait_done("after_burst", 2000);
        check("overflow_still_set", overflow, 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("overflow_cleared", overflow, 0);

        // Reset during the second digit; the queued BEEF must be discarded.
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h41);
        drive(16'h1A2F);
        drive(16'hBEEF);
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("mid_two_digits_seen", exp_q.size(), 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_start", tx_start, 0);
        check("midrst_tx_data", tx_data, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_overflow", overflow, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_fifo_empty", busy, 0);
        expect_str("00C3");
        drive(16'h00C3);
        saw_start = 1'b0;
        n = 0;
        while (!tx_ready && n < 500) begin
            if (tx_start) saw_start = 1'b1;
            @(negedge clk);
            n++;
        end
        check("midrst_wait_ready", tx_ready, 1);
        check("midrst_no_early_start", saw_start, 0);
        wait_done("after_rst", 2000);
        check("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
